// File: rtl/async_serial_pkg.sv
// Shared definitions for the asynchronous serial link: FSM encoding, line
// levels, frame length and the parity rule used by transmitter and receiver.
package async_serial_pkg;

    // Transmitter frame sequencing states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_GAP    = 3'd5
    } tx_state_e;

    // Line levels for each part of the frame
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b0;
    localparam logic GAP_LEVEL   = 1'b1;

    // Start, parity and stop bits on top of the data bits (gap bit excluded)
    localparam int FRAME_OVERHEAD_BITS = 3;

    // Widest data word the parity helper accepts; narrower words are zero-extended
    localparam int MAX_DATA_BITS = 32;

    function automatic int frame_bits(input int data_bits);
        return data_bits + FRAME_OVERHEAD_BITS;
    endfunction

    // Odd parity: data bits plus the returned bit always hold an odd number of ones.
    // Zero-extension leaves the XOR unchanged.
    function automatic logic odd_parity(input logic [MAX_DATA_BITS-1:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/async_bit_timer.sv
// Bit timer: while enabled, emits a one-cycle bit_end pulse on the last clock
// of every BIT_CYCLES-long bit period. clear restarts the period count.
module async_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic Clk,
    input  logic Rst_n,
    input  logic enable,
    input  logic clear,
    output logic bit_end
);

    localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(BIT_CYCLES - 1);

    logic [CW-1:0] cycle_cnt;

    // Count clocks within the current bit, wrapping at the bit boundary
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cycle_cnt <= '0;
        end else if (clear) begin
            cycle_cnt <= '0;
        end else if (enable) begin
            if (cycle_cnt == LAST_CYCLE) begin
                cycle_cnt <= '0;
            end else begin
                cycle_cnt <= cycle_cnt + 1'b1;
            end
        end
    end

    assign bit_end = enable && (cycle_cnt == LAST_CYCLE);

endmodule

// File: rtl/async_transmitter.sv
// Asynchronous serial transmitter with one-word holding register.
// Frame: start(0), DATA_BITS data LSB first, odd parity, stop(0), gap(1).
//
// Handshake: a word is taken on any rising edge where Start=1 and Ready=1
// (and reset has been released for at least one edge). Ready=1 means the
// holding register is empty. If the line is idle, or the current frame is in
// its final gap clock, the word goes straight to the shift register;
// otherwise it waits in the holding register and Ready drops until the gap
// of the current frame ends.
module async_transmitter
    import async_serial_pkg::*;
#(
    parameter int DATA_BITS  = 5,
    parameter int BIT_CYCLES = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [DATA_BITS-1:0] Din,
    input  logic                 Start,
    output logic                 Ready,
    output logic                 Busy,
    output logic                 Tx,
    output tx_state_e            State
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    localparam int NEXT_IDX = (DATA_BITS > 1) ? 1 : 0;

    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] hold_reg;
    logic                 parity_bit;
    logic [BW-1:0]        bit_cnt;
    logic                 armed;
    logic                 accept;
    logic                 bit_end;
    logic                 gap_end;

    // armed stays low for the first edge after reset so that edge ignores Start
    assign accept  = Start && Ready && armed;
    assign gap_end = (State == S_GAP) && bit_end;

    async_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .Clk    (Clk),
        .Rst_n  (Rst_n),
        .enable (State != S_IDLE),
        .clear  ((State == S_IDLE) && accept),
        .bit_end(bit_end)
    );

    // Frame sequencer: state, shift register, holding register and registered outputs
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            State      <= S_IDLE;
            Tx         <= IDLE_LEVEL;
            Ready      <= 1'b1;
            Busy       <= 1'b0;
            shift_reg  <= '0;
            hold_reg   <= '0;
            parity_bit <= 1'b0;
            bit_cnt    <= '0;
            armed      <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (State)
                S_IDLE: begin
                    if (accept) begin
                        shift_reg  <= Din;
                        parity_bit <= odd_parity(MAX_DATA_BITS'(Din));
                        bit_cnt    <= '0;
                        State      <= S_START;
                        Tx         <= START_LEVEL;
                        Busy       <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        State <= S_DATA;
                        Tx    <= shift_reg[0];
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == LAST_BIT) begin
                            State <= S_PARITY;
                            Tx    <= parity_bit;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            Tx        <= shift_reg[NEXT_IDX];
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        State <= S_STOP;
                        Tx    <= STOP_LEVEL;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        State <= S_GAP;
                        Tx    <= GAP_LEVEL;
                    end
                end
                S_GAP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (!Ready) begin
                            // Held word becomes the next frame; holding empties
                            shift_reg  <= hold_reg;
                            parity_bit <= odd_parity(MAX_DATA_BITS'(hold_reg));
                            State      <= S_START;
                            Tx         <= START_LEVEL;
                            Ready      <= 1'b1;
                        end else if (accept) begin
                            // Word offered in the final gap clock starts back-to-back
                            shift_reg  <= Din;
                            parity_bit <= odd_parity(MAX_DATA_BITS'(Din));
                            State      <= S_START;
                            Tx         <= START_LEVEL;
                        end else begin
                            State <= S_IDLE;
                            Tx    <= IDLE_LEVEL;
                            Busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    State <= S_IDLE;
                    Tx    <= IDLE_LEVEL;
                    Busy  <= 1'b0;
                end
            endcase

            // A word accepted mid-frame waits in the holding register
            if (accept && (State != S_IDLE) && !gap_end) begin
                hold_reg <= Din;
                Ready    <= 1'b0;
            end
        end
    end

endmodule
